// File: rtl/wlan_sync_corr_window_sum_if.sv
// wlan_sync_corr_window_sum_if
//   Valid/ready stream carrying one signed complex word (re, im) per transfer.
//   The producer side uses the master modport, the consumer side uses slave.
// Ports (signals)
//   valid  producer -> consumer  word is presented this cycle
//   ready  consumer -> producer  consumer takes the word this cycle
//   re     producer -> consumer  signed real part, W bits
//   im     producer -> consumer  signed imaginary part, W bits
interface wlan_sync_corr_window_sum_if #(
  parameter int W = 72
);
  logic         valid;
  logic         ready;
  logic [W-1:0] re;
  logic [W-1:0] im;

  modport master (
    output valid,
    output re,
    output im,
    input  ready
  );

  modport slave (
    input  valid,
    input  re,
    input  im,
    output ready
  );
endinterface

// File: rtl/wlan_sync_corr_window_sum.sv
// wlan_sync_corr_window_sum
//   Sliding-window complex accumulator for the L-STF autocorrelator. Each
//   accepted conjugate product is added to a running sum while the product that
//   entered WIN samples earlier is subtracted, using a circular delay line. The
//   sum of the last WIN products is presented on a one-deep output register.
// Ports
//   ap_clk  in      rising-edge clock
//   ap_rst  in      asynchronous active-high reset
//   clear   in      synchronous flush of all window state
//   s       slave   input products (PROD_W-bit re/im), valid/ready
//   m       master  window sums (ACC_W-bit re/im), valid/ready
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | fewer than WIN products accepted since reset/clear; delay line is
//       | treated as zero, no output produced
// RUN   | window full; every accept subtracts the oldest product and loads
//       | the output register
module wlan_sync_corr_window_sum #(
  parameter int PROD_W = 72,
  parameter int WIN    = 16,
  parameter int ACC_W  = 76
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic                           clear,
  wlan_sync_corr_window_sum_if.slave     s,
  wlan_sync_corr_window_sum_if.master    m
);

  localparam int PTR_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(WIN - 1);

  if (WIN < 2 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
    $error("WIN must be a power of two and at least 2");
  end
  if (ACC_W < PROD_W + PTR_W) begin : g_bad_accw
    $error("ACC_W too narrow to hold WIN products without overflow");
  end

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [PTR_W-1:0]         wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]         fill_cnt, fill_cnt_nxt;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [ACC_W-1:0]  acc_re_nxt, acc_im_nxt;
  logic                     m_valid_q, m_valid_nxt;
  logic signed [ACC_W-1:0]  m_re_q, m_im_q;
  logic                     load;
  logic                     s_ready;
  logic                     accept;
  logic [PROD_W-1:0]        old_re, old_im;

  // Delay line; deliberately not reset. Stale contents are masked while in FILL.
  logic [PROD_W-1:0]        dly_re [WIN];
  logic [PROD_W-1:0]        dly_im [WIN];

  function automatic logic signed [ACC_W-1:0] sext(input logic [PROD_W-1:0] v);
    return {{(ACC_W - PROD_W){v[PROD_W-1]}}, v};
  endfunction

  // Output register is one deep with no bubble: a new sum may be loaded in
  // the same cycle the previous one is taken.
  assign s_ready = !clear && (!m_valid_q || m.ready);
  assign accept  = s.valid && s_ready;

  assign s.ready = s_ready;
  assign m.valid = m_valid_q;
  assign m.re    = m_re_q;
  assign m.im    = m_im_q;

  // Read of the oldest slot happens before it is overwritten on the same edge.
  assign old_re = (state == FILL) ? '0 : dly_re[wr_ptr];
  assign old_im = (state == FILL) ? '0 : dly_im[wr_ptr];

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    fill_cnt_nxt = fill_cnt;
    acc_re_nxt   = acc_re;
    acc_im_nxt   = acc_im;
    load         = 1'b0;

    if (accept) begin
      acc_re_nxt = acc_re + sext(s.re) - sext(old_re);
      acc_im_nxt = acc_im + sext(s.im) - sext(old_im);
      wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;

      case (state)
        FILL: begin
          if (fill_cnt == LAST) begin
            state_nxt    = RUN;
            fill_cnt_nxt = '0;
            load         = 1'b1;
          end else begin
            fill_cnt_nxt = fill_cnt + 1'b1;
          end
        end
        RUN: begin
          load = 1'b1;
        end
        default: begin
          state_nxt = FILL;
        end
      endcase
    end

    if (load) begin
      m_valid_nxt = 1'b1;
    end else if (m.ready) begin
      m_valid_nxt = 1'b0;
    end else begin
      m_valid_nxt = m_valid_q;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      m_valid_q <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
    end else if (clear) begin
      state     <= FILL;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      m_valid_q <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      fill_cnt  <= fill_cnt_nxt;
      acc_re    <= acc_re_nxt;
      acc_im    <= acc_im_nxt;
      m_valid_q <= m_valid_nxt;
      if (load) begin
        m_re_q <= acc_re_nxt;
        m_im_q <= acc_im_nxt;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (accept) begin
      dly_re[wr_ptr] <= s.re;
      dly_im[wr_ptr] <= s.im;
    end
  end

endmodule

// File: tb/tb_wlan_sync_corr_window_sum.sv
// tb_wlan_sync_corr_window_sum
//   Directed stimulus with hand-derived window sums pushed to a scoreboard;
//   a monitor pops and compares every output transfer.
module tb_wlan_sync_corr_window_sum;

  localparam int PW = 72;
  localparam int AW = 76;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic clear  = 1'b0;

  int tests = 0;
  int fails = 0;

  logic signed [AW-1:0] exp_re_q [$];
  logic signed [AW-1:0] exp_im_q [$];

  wlan_sync_corr_window_sum_if #(.W(PW)) s_if ();
  wlan_sync_corr_window_sum_if #(.W(AW)) m_if ();

  wlan_sync_corr_window_sum #(.PROD_W(PW), .WIN(16), .ACC_W(AW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .clear  (clear),
    .s      (s_if),
    .m      (m_if)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic signed [AW-1:0] re, input logic signed [AW-1:0] im);
    exp_re_q.push_back(re);
    exp_im_q.push_back(im);
  endtask

  // Presents one product and returns #1 after the edge that accepted it.
  task automatic send(input logic [PW-1:0] re, input logic [PW-1:0] im);
    int  n;
    bit  took;
    s_if.valid = 1'b1;
    s_if.re    = re;
    s_if.im    = im;
    n          = 0;
    do begin
      @(negedge ap_clk);
      took = s_if.ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!took && n < 50);
    if (!took) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready stayed %0b, expected 1", s_if.ready);
    end
    s_if.valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge ap_clk);
    chk("clear_s_ready", AW'(s_if.ready), AW'(0));
    @(posedge ap_clk);
    #1;
    clear = 1'b0;
    chk("clear_m_valid", AW'(m_if.valid), AW'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer completes on the edge after a negedge
  // where valid and ready are both high.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (m_if.valid && m_if.ready) begin
        if (exp_re_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got re=%0d im=%0d with empty scoreboard",
                   $signed(m_if.re), $signed(m_if.im));
        end else begin
          chk("sum_re", m_if.re, exp_re_q.pop_front());
          chk("sum_im", m_if.im, exp_im_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    logic signed [PW-1:0] pmin, pmax;
    logic signed [AW-1:0] emin, emax, er, ei;

    s_if.valid = 1'b0;
    s_if.re    = '0;
    s_if.im    = '0;
    m_if.ready = 1'b1;

    #12;
    chk("rst_m_valid", AW'(m_if.valid), AW'(0));
    chk("rst_m_re", m_if.re, AW'(0));
    chk("rst_m_im", m_if.im, AW'(0));
    chk("rst_s_ready", AW'(s_if.ready), AW'(1));
    ap_rst = 1'b0;
    idle(2);

    // Constant (1,-1)
    for (int i = 0; i < 5; i++) push(AW'(16), -AW'(16));
    for (int i = 1; i <= 20; i++) begin
      send(PW'(1), -PW'(1));
      if (i == 15) chk("t1_no_valid_before_16", AW'(m_if.valid), AW'(0));
      if (i == 16) begin
        chk("t1_valid_after_16", AW'(m_if.valid), AW'(1));
        chk("t1_first_re", m_if.re, AW'(16));
      end
    end
    idle(3);
    do_clear();

    // Ramp 1..20
    for (int k = 0; k < 5; k++) push(AW'(136 + 16 * k), AW'(0));
    for (int i = 1; i <= 20; i++) send(PW'(i), PW'(0));
    idle(3);
    do_clear();

    // Ramp with a 3-cycle downstream stall after the first output
    for (int k = 0; k < 5; k++) push(AW'(136 + 16 * k), AW'(0));
    for (int i = 1; i <= 16; i++) send(PW'(i), PW'(0));
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.re    = PW'(17);
    s_if.im    = '0;
    repeat (3) begin
      @(negedge ap_clk);
      chk("t3_stall_s_ready", AW'(s_if.ready), AW'(0));
      chk("t3_stall_m_valid", AW'(m_if.valid), AW'(1));
      chk("t3_stall_m_re", m_if.re, AW'(136));
      @(posedge ap_clk);
      #1;
    end
    m_if.ready = 1'b1;
    for (int i = 17; i <= 20; i++) send(PW'(i), PW'(0));
    idle(3);
    do_clear();

    // Extremes: most negative then most positive products
    pmin = {1'b1, {(PW-1){1'b0}}};
    pmax = {1'b0, {(PW-1){1'b1}}};
    emin = pmin;
    emax = pmax;
    for (int k = 0; k <= 16; k++) begin
      er = (AW'(16 - k)) * emin + (AW'(k)) * emax;
      ei = (AW'(16 - k)) * emax + (AW'(k)) * emin;
      push(er, ei);
    end
    for (int i = 1; i <= 16; i++) send(pmin, pmax);
    chk("t4_first_re", m_if.re, {1'b1, {(AW-1){1'b0}}});
    for (int i = 1; i <= 16; i++) send(pmax, pmin);
    chk("t4_last_re", m_if.re, AW'(16) * emax);
    idle(3);
    do_clear();

    // Async reset mid-stream with an output pending
    for (int k = 0; k < 4; k++) push(AW'(16), AW'(16));
    for (int i = 1; i <= 20; i++) send(PW'(1), PW'(1));
    m_if.ready = 1'b0;
    chk("t5_pending_valid", AW'(m_if.valid), AW'(1));
    #2;
    ap_rst = 1'b1;
    #1;
    chk("t5_rst_m_valid", AW'(m_if.valid), AW'(0));
    chk("t5_rst_m_re", m_if.re, AW'(0));
    @(negedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    m_if.ready = 1'b1;
    for (int k = 0; k < 3; k++) push(AW'(32), AW'(32));
    for (int i = 1; i <= 18; i++) begin
      send(PW'(2), PW'(2));
      if (i == 15) chk("t5_no_valid_before_16", AW'(m_if.valid), AW'(0));
      if (i == 16) chk("t5_first_re", m_if.re, AW'(32));
    end
    idle(3);
    do_clear();

    // clear coinciding with a valid sample while in RUN
    for (int k = 0; k < 2; k++) push(AW'(16), AW'(16));
    for (int i = 1; i <= 18; i++) send(PW'(1), PW'(1));
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.re    = PW'(5);
    s_if.im    = PW'(5);
    clear      = 1'b1;
    @(negedge ap_clk);
    chk("t6_clear_s_ready", AW'(s_if.ready), AW'(0));
    @(posedge ap_clk);
    #1;
    clear      = 1'b0;
    s_if.valid = 1'b0;
    chk("t6_clear_m_valid", AW'(m_if.valid), AW'(0));
    m_if.ready = 1'b1;
    push(AW'(64), AW'(64));
    for (int i = 1; i <= 16; i++) begin
      send(PW'(4), PW'(4));
      if (i == 15) chk("t6_no_valid_before_16", AW'(m_if.valid), AW'(0));
      if (i == 16) chk("t6_first_re", m_if.re, AW'(64));
    end
    idle(5);

    chk("scoreboard_drained", AW'(exp_re_q.size()), AW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
